// File: rtl/pwm_writer_nch_if.sv
// AXI4-Lite bus bundle for the PWM writer register port.
// Ports: write address (aw*), write data (w*), write response (b*),
//        read address (ar*), read data (r*); slave/master modports.
interface pwm_writer_nch_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pwm_writer_nch.sv
// NUM_CH-channel PWM generator behind an AXI4-Lite register file.
// One prescaled period counter is shared by all channels; period and duty
// values are double-buffered and commit only when the counter wraps.
// Ports: ACLK, ARESETN (async active-low), s_axi (AXI4-Lite slave),
//        pwm_out[NUM_CH] registered PWM outputs.
module pwm_writer_nch #(
  parameter int unsigned NUM_CH             = 8,
  parameter int unsigned CNT_W              = 20,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  pwm_writer_nch_if.slave    s_axi,
  output logic [NUM_CH-1:0]  pwm_out
);
  localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
  localparam int unsigned WIDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned PRE_W  = 16;
  localparam int unsigned STAT_W = 16;

  localparam logic [WIDX_W-1:0] A_CTRL   = WIDX_W'(0);
  localparam logic [WIDX_W-1:0] A_PRE    = WIDX_W'(1);
  localparam logic [WIDX_W-1:0] A_PERIOD = WIDX_W'(2);
  localparam logic [WIDX_W-1:0] A_CH_EN  = WIDX_W'(3);
  localparam logic [WIDX_W-1:0] A_POL    = WIDX_W'(4);
  localparam logic [WIDX_W-1:0] A_STATUS = WIDX_W'(5);

  // Programmed registers
  logic                r_gen;
  logic [PRE_W-1:0]    r_prescale;
  logic [CNT_W-1:0]    r_period;
  logic [NUM_CH-1:0]   r_ch_en;
  logic [NUM_CH-1:0]   r_pol;
  logic [CNT_W-1:0]    r_duty [NUM_CH];

  // Live counters and committed (active) copies
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_period_act;
  logic [CNT_W-1:0]    r_duty_act [NUM_CH];
  logic [STAT_W-1:0]   r_status;
  logic [NUM_CH-1:0]   r_pwm;

  // AXI handshake state
  logic                r_awready;
  logic                r_bvalid;
  logic                r_arready;
  logic                r_rvalid;
  logic [DW-1:0]       r_rdata;

  logic                w_wr_en;
  logic                w_rd_en;
  logic [WIDX_W-1:0]   w_wr_idx;
  logic [WIDX_W-1:0]   w_rd_idx;
  logic [DW-1:0]       w_rdata;
  logic                w_gen_rise;
  logic                w_tick;
  logic                w_wrap;
  logic [NUM_CH-1:0]   w_raw;
  logic                w_unused;

  assign w_wr_en  = r_awready & s_axi.awvalid & s_axi.wvalid;
  assign w_rd_en  = r_arready & s_axi.arvalid;
  assign w_wr_idx = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_rd_idx = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  // Bus inputs that carry no meaning here (full-word writes only)
  assign w_unused = ^{s_axi.awprot, s_axi.arprot, s_axi.wstrb, s_axi.wdata,
                      s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_awready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = 2'b00;
  assign pwm_out       = r_pwm;

  // Read-data mux; unmapped words and unused bits read 0
  always_comb begin
    w_rdata = '0;
    case (w_rd_idx)
      A_CTRL:   w_rdata[0]          = r_gen;
      A_PRE:    w_rdata[PRE_W-1:0]  = r_prescale;
      A_PERIOD: w_rdata[CNT_W-1:0]  = r_period;
      A_CH_EN:  w_rdata[NUM_CH-1:0] = r_ch_en;
      A_POL:    w_rdata[NUM_CH-1:0] = r_pol;
      A_STATUS: w_rdata[STAT_W-1:0] = r_status;
      default:  ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_rd_idx == WIDX_W'(16 + i)) w_rdata[CNT_W-1:0] = r_duty[i];
    end
  end

  // AXI handshakes and register writes
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awready  <= 1'b0;
      r_bvalid   <= 1'b0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_gen      <= 1'b0;
      r_prescale <= PRE_W'(99);
      r_period   <= CNT_W'(19999);
      r_ch_en    <= '0;
      r_pol      <= '0;
      for (int i = 0; i < NUM_CH; i++) r_duty[i] <= '0;
    end else begin
      // One-cycle ready pulse; blocked while a write response is pending
      r_awready <= s_axi.awvalid & s_axi.wvalid & ~r_awready & ~r_bvalid;
      if (w_wr_en)           r_bvalid <= 1'b1;
      else if (s_axi.bready) r_bvalid <= 1'b0;

      r_arready <= s_axi.arvalid & ~r_arready & ~r_rvalid;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
      end else if (s_axi.rready) begin
        r_rvalid <= 1'b0;
      end

      if (w_wr_en) begin
        case (w_wr_idx)
          A_CTRL:   r_gen      <= s_axi.wdata[0];
          A_PRE:    r_prescale <= s_axi.wdata[PRE_W-1:0];
          A_PERIOD: r_period   <= s_axi.wdata[CNT_W-1:0];
          A_CH_EN:  r_ch_en    <= s_axi.wdata[NUM_CH-1:0];
          A_POL:    r_pol      <= s_axi.wdata[NUM_CH-1:0];
          default:  ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_wr_idx == WIDX_W'(16 + i)) r_duty[i] <= s_axi.wdata[CNT_W-1:0];
        end
      end
    end
  end

  assign w_gen_rise = w_wr_en & (w_wr_idx == A_CTRL) & s_axi.wdata[0] & ~r_gen;
  // >= keeps the prescaler bounded if PRESCALE is lowered below pre_cnt
  assign w_tick     = r_gen & (r_pre_cnt >= r_prescale);
  assign w_wrap     = w_tick & (r_cnt >= r_period_act);

  always_comb begin
    w_raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_raw[i] = r_ch_en[i] & r_gen & (r_cnt < r_duty_act[i]);
    end
  end

  // Prescaler, period counter, shadow commit and output stage
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_pre_cnt    <= '0;
      r_cnt        <= '0;
      r_period_act <= CNT_W'(19999);
      r_status     <= '0;
      r_pwm        <= '0;
      for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= '0;
    end else begin
      if (w_gen_rise) begin
        // Enabling loads the programmed values and restarts from 0
        r_pre_cnt    <= '0;
        r_cnt        <= '0;
        r_period_act <= r_period;
        for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= r_duty[i];
      end else if (!r_gen) begin
        r_pre_cnt <= '0;
        r_cnt     <= '0;
      end else begin
        r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
        if (w_wrap) begin
          r_cnt        <= '0;
          r_period_act <= r_period;
          for (int i = 0; i < NUM_CH; i++) r_duty_act[i] <= r_duty[i];
          r_status     <= r_status + STAT_W'(1);
        end else if (w_tick) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      r_pwm <= w_raw ^ r_pol;
    end
  end
endmodule

// File: tb/tb_pwm_writer_nch.sv
// Randomised and directed bench for pwm_writer_nch against a period-position
// model: the model tracks elapsed cycles within the current period and
// derives the counter value as position / (PRESCALE+1).
module tb_pwm_writer_nch;
  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CNT_W  = 20;

  logic              ACLK;
  logic              ARESETN;
  logic [NUM_CH-1:0] pwm_out;

  pwm_writer_nch_if #(.ADDR_W(7), .DATA_W(32)) s_axi ();

  pwm_writer_nch #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W),
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(s_axi), .pwm_out(pwm_out)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting at t=%0t", nm, $time);
  endtask

  // ---------------- behavioural model ----------------
  int unsigned       m_gen, m_pre, m_period, m_ch_en, m_pol, m_status, m_period_act;
  int unsigned       m_duty [NUM_CH];
  int unsigned       m_duty_act [NUM_CH];
  longint unsigned   m_pos;
  logic [NUM_CH-1:0] m_pwm;
  logic [31:0]       m_rq [$];

  function automatic void model_reset();
    m_gen = 0; m_pre = 99; m_period = 19999; m_ch_en = 0; m_pol = 0;
    m_status = 0; m_period_act = 19999; m_pos = 0; m_pwm = '0;
    for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; m_duty_act[i] = 0; end
  endfunction

  function automatic logic [31:0] model_read(input logic [6:0] a);
    int unsigned w = 32'(a[6:2]);
    logic [31:0] d = '0;
    case (w)
      0: d = m_gen;
      1: d = m_pre;
      2: d = m_period;
      3: d = m_ch_en;
      4: d = m_pol;
      5: d = m_status;
      default: if (w >= 16 && w < 16 + NUM_CH) d = m_duty[w-16];
    endcase
    return d;
  endfunction

  function automatic logic [NUM_CH-1:0] model_eval();
    longint unsigned cnt = (m_gen != 0) ? m_pos / (m_pre + 1) : 0;
    logic [NUM_CH-1:0] e;
    for (int i = 0; i < NUM_CH; i++) begin
      e[i] = ((m_gen != 0) && m_ch_en[i] && (cnt < m_duty_act[i])) ^ m_pol[i];
    end
    return e;
  endfunction

  // One clock of elapsed time: wrap after (PERIOD+1)*(PRESCALE+1) cycles
  function automatic void model_advance();
    if (m_gen != 0) begin
      m_pos++;
      if (m_pos == (longint'(m_period_act) + 1) * (m_pre + 1)) begin
        m_pos = 0;
        m_period_act = m_period;
        for (int i = 0; i < NUM_CH; i++) m_duty_act[i] = m_duty[i];
        m_status = (m_status + 1) % 65536;
      end
    end else begin
      m_pos = 0;
    end
  endfunction

  function automatic void model_write(input logic [6:0] a, input logic [31:0] d);
    int unsigned w = 32'(a[6:2]);
    case (w)
      0: begin
        if (d[0] && m_gen == 0) begin
          m_pos = 0;
          m_period_act = m_period;
          for (int i = 0; i < NUM_CH; i++) m_duty_act[i] = m_duty[i];
        end
        m_gen = 32'(d[0]);
      end
      1: m_pre    = d & 32'h0000_FFFF;
      2: m_period = d & ((32'd1 << CNT_W) - 1);
      3: m_ch_en  = d & ((32'd1 << NUM_CH) - 1);
      4: m_pol    = d & ((32'd1 << NUM_CH) - 1);
      default: if (w >= 16 && w < 16 + NUM_CH) m_duty[w-16] = d & ((32'd1 << CNT_W) - 1);
    endcase
  endfunction

  // Compare process: sampled mid-cycle, then model steps across the next edge
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      check("rst_pwm", 64'(pwm_out), 0);
      check("rst_bvalid", 64'(s_axi.bvalid), 0);
      check("rst_rvalid", 64'(s_axi.rvalid), 0);
      check("rst_awready", 64'(s_axi.awready), 0);
      check("rst_arready", 64'(s_axi.arready), 0);
      check("rst_rdata", 64'(s_axi.rdata), 0);
      model_reset();
      m_rq.delete();
    end else begin
      check("pwm_out", 64'(pwm_out), 64'(m_pwm));
      check("aw_w_ready_pair", 64'(s_axi.awready), 64'(s_axi.wready));
      if (s_axi.bvalid) begin
        check("awready_while_b_pending", 64'(s_axi.awready), 0);
        check("bresp", 64'(s_axi.bresp), 0);
      end
      if (s_axi.rvalid && s_axi.rready) begin
        if (m_rq.size() == 0) timeout_fail("rdata_unexpected");
        else check("rdata", 64'(s_axi.rdata), 64'(m_rq.pop_front()));
        check("rresp", 64'(s_axi.rresp), 0);
      end
      m_pwm = model_eval();
      if (s_axi.arvalid && s_axi.arready) m_rq.push_back(model_read(s_axi.araddr));
      model_advance();
      if (s_axi.awvalid && s_axi.wvalid && s_axi.awready) model_write(s_axi.awaddr, s_axi.wdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge ACLK); #1; end
  endtask

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d);
    int n = 0;
    s_axi.awaddr = a; s_axi.wdata = d; s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
    while (!s_axi.awready && n < 50) begin cyc(1); n++; end
    if (n >= 50) timeout_fail("awready_wait");
    cyc(1);
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    n = 0;
    while (!s_axi.bvalid && n < 50) begin cyc(1); n++; end
    if (n >= 50) timeout_fail("bvalid_wait");
    cyc(1);
  endtask

  task automatic axi_read(input logic [6:0] a, output logic [31:0] d);
    int n = 0;
    s_axi.araddr = a; s_axi.arvalid = 1'b1;
    while (!s_axi.arready && n < 50) begin cyc(1); n++; end
    if (n >= 50) timeout_fail("arready_wait");
    cyc(1);
    s_axi.arvalid = 1'b0;
    n = 0;
    while (!s_axi.rvalid && n < 50) begin cyc(1); n++; end
    if (n >= 50) timeout_fail("rvalid_wait");
    d = s_axi.rdata;
    cyc(1);
  endtask

  task automatic count_high(input int ch, input int n, output int c);
    c = 0;
    repeat (n) begin cyc(1); if (pwm_out[ch]) c++; end
  endtask

  task automatic wait_rise(input int ch);
    logic prev = pwm_out[ch];
    int n = 0;
    while (n < 200) begin
      cyc(1); n++;
      if (!prev && pwm_out[ch]) return;
      prev = pwm_out[ch];
    end
    timeout_fail("wait_rise");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] d, s1, s2;
    int c, n, len;
    ARESETN = 1'b0;
    s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b0; s_axi.bready = 1'b1;
    s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
    model_reset();
    cyc(3);
    ARESETN = 1'b1;
    cyc(1);

    // Reset readback
    axi_read(7'h04, d); check("reset_prescale", 64'(d), 99);
    axi_read(7'h08, d); check("reset_period", 64'(d), 19999);
    axi_read(7'h0C, d); check("reset_ch_en", 64'(d), 0);
    axi_read(7'h40, d); check("reset_duty0", 64'(d), 0);
    check("reset_pwm", 64'(pwm_out), 0);

    // Basic PWM: 10-cycle period, 3 high
    axi_write(7'h04, 0); axi_write(7'h08, 9); axi_write(7'h40, 3);
    axi_write(7'h0C, 1); axi_write(7'h00, 1);
    cyc(20);
    count_high(0, 10, c); check("basic_high_cycles", 64'(c), 3);
    axi_read(7'h14, s1); cyc(7); axi_read(7'h14, s2);
    check("status_per_10_cycles", 64'(s2 - s1), 1);

    // Shadowed duty update mid-period
    wait_rise(0); cyc(3);
    axi_write(7'h40, 7);
    wait_rise(0);
    len = 1; n = 0;
    while (pwm_out[0] && n < 50) begin cyc(1); n++; if (pwm_out[0]) len++; end
    check("shadow_next_high", 64'(len), 7);

    // Boundaries
    axi_write(7'h44, 0); axi_write(7'h48, 12);
    axi_write(7'h10, 32'h08); axi_write(7'h0C, 32'h07);
    cyc(25);
    count_high(1, 10, c); check("duty0_const_low", 64'(c), 0);
    count_high(2, 10, c); check("duty_gt_period_const_high", 64'(c), 10);
    count_high(3, 10, c); check("pol_disabled_const_high", 64'(c), 10);

    // Prescaler, then disable
    axi_write(7'h00, 0); axi_write(7'h04, 2); axi_write(7'h08, 3); axi_write(7'h40, 2);
    axi_write(7'h00, 1);
    cyc(30);
    count_high(0, 12, c); check("prescaled_high_cycles", 64'(c), 6);
    axi_write(7'h00, 0);
    check("disable_idle_pol", 64'(pwm_out), 64'h08);
    axi_read(7'h14, s1); cyc(20); axi_read(7'h14, s2);
    check("status_frozen", 64'(s2), 64'(s1));

    // Randomised traffic
    for (int r = 0; r < 6; r++) begin
      axi_write(7'h00, 0);
      axi_write(7'h04, $urandom_range(3, 0));
      axi_write(7'h08, $urandom_range(12, 0));
      axi_write(7'h00, 1);
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(6, 0))
          0: axi_write(7'(7'h40 + 4 * $urandom_range(NUM_CH - 1, 0)), $urandom_range(15, 0));
          1: axi_write(7'h0C, $urandom);
          2: axi_write(7'h10, $urandom);
          3: axi_write(7'h08, $urandom_range(12, 0));
          4: axi_write(7'(4 * $urandom_range(31, 24)), $urandom);
          5: axi_read(7'(4 * $urandom_range(31, 0)), d);
          default: cyc($urandom_range(15, 0));
        endcase
      end
    end

    // Back-to-back writes with BREADY held low
    s_axi.bready = 1'b0;
    s_axi.awaddr = 7'h40; s_axi.wdata = 5; s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
    n = 0;
    while (!s_axi.awready && n < 50) begin cyc(1); n++; end
    if (n >= 50) timeout_fail("b2b_first_aw");
    cyc(1);
    s_axi.awaddr = 7'h44; s_axi.wdata = 6;
    c = 0;
    repeat (5) begin cyc(1); if (s_axi.awready) c++; end
    check("no_second_awready", 64'(c), 0);
    check("bvalid_held", 64'(s_axi.bvalid), 1);
    s_axi.bready = 1'b1;
    n = 0;
    while (!s_axi.awready && n < 50) begin cyc(1); n++; end
    if (n >= 50) timeout_fail("b2b_second_aw");
    cyc(1);
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    cyc(2);
    axi_read(7'h40, d); check("b2b_duty0", 64'(d), 5);
    axi_read(7'h44, d); check("b2b_duty1", 64'(d), 6);
    axi_read(7'h30, d); check("unmapped_read", 64'(d), 0);

    // Reset in the middle of a write response
    s_axi.bready = 1'b0;
    s_axi.awaddr = 7'h08; s_axi.wdata = 7; s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
    n = 0;
    while (!s_axi.awready && n < 50) begin cyc(1); n++; end
    if (n >= 50) timeout_fail("rst_aw");
    cyc(1);
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    ARESETN = 1'b0;
    #1;
    check("reset_drops_bvalid", 64'(s_axi.bvalid), 0);
    cyc(2);
    ARESETN = 1'b1;
    s_axi.bready = 1'b1;
    cyc(1);
    axi_read(7'h08, d); check("post_reset_period", 64'(d), 19999);
    axi_read(7'h04, d); check("post_reset_prescale", 64'(d), 99);
    axi_read(7'h40, d); check("post_reset_duty0", 64'(d), 0);
    axi_read(7'h00, d); check("post_reset_ctrl", 64'(d), 0);
    check("post_reset_pwm", 64'(pwm_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
